uwire_responder: RTL and testbench

//  Target-side MICROWIRE (uWire) endpoint: models the LMK01801 configuration port on
//  the device end of the CLKUWIRE/DATAUWIRE/LEUWIRE bus.

---
 rtl/uwire_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_uwire_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uwire_responder.sv
// Target-side MICROWIRE endpoint: oversampled deserializer with a 28-bit register file.
// Optional readback serializer is enabled by defining UWIRE_READBACK_EN.
module uwire_responder #(
  parameter int unsigned NREG    = 16,
  parameter int unsigned RB_ADDR = 15,
  parameter int unsigned SYNC    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uw_clk,
  input  logic        uw_le,
  input  logic        uw_din,
  output logic        uw_dout,
  output logic        uw_doe,
  output logic        wr_stb,
  output logic [3:0]  wr_addr,
  output logic [27:0] wr_data,
  output logic        frame_err,
  input  logic [3:0]  rd_addr,
  output logic [27:0] rd_data
);

  localparam int unsigned DW  = 28;
  localparam int unsigned AW  = 4;
  localparam int unsigned FW  = 32;
  localparam int unsigned CW  = 6;
  localparam int unsigned IW  = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned STW = $clog2(SYNC + 1) + 1;
  localparam logic [AW:0] NREG_L = 5'(NREG);

  // SETTLE lets the synchronizers flush after reset; WAIT swallows a frame already in flight.
  typedef enum logic [1:0] {ST_SETTLE, ST_IDLE, ST_SHIFT, ST_WAIT} state_e;

  state_e              state_q, state_d;
  logic [SYNC-1:0]     le_sync_q, le_sync_d, clk_sync_q, clk_sync_d, din_sync_q, din_sync_d;
  logic                le_h_q, clk_h_q;
  logic [STW-1:0]      settle_q, settle_d;
  logic [FW-1:0]       sr_q, sr_d;
  logic [CW-1:0]       bitcnt_q, bitcnt_d;
  logic                wr_stb_q, wr_stb_d, frame_err_q, frame_err_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [DW-1:0]       wr_data_q, wr_data_d, rd_data_q, rd_data_d;
  logic [DW-1:0]       regs_q [NREG];
  logic [DW-1:0]       regs_d [NREG];
  logic                le_s, clk_s, din_s;
  logic                le_rise_c, le_fall_c, clk_rise_c, commit_c;
  logic [AW-1:0]       fr_addr_c;
  logic [DW-1:0]       fr_data_c;

  assign le_s       = le_sync_q[SYNC-1];
  assign clk_s      = clk_sync_q[SYNC-1];
  assign din_s      = din_sync_q[SYNC-1];
  assign le_rise_c  = le_s & ~le_h_q;
  assign le_fall_c  = ~le_s & le_h_q;
  assign clk_rise_c = clk_s & ~clk_h_q;
  assign fr_addr_c  = sr_q[AW-1:0];
  assign fr_data_c  = sr_q[FW-1:AW];

  always_comb begin
    le_sync_d  = {le_sync_q[SYNC-2:0], uw_le};
    clk_sync_d = {clk_sync_q[SYNC-2:0], uw_clk};
    din_sync_d = {din_sync_q[SYNC-2:0], uw_din};
  end

  // Frame FSM, register file write and local read port
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    sr_d        = sr_q;
    bitcnt_d    = bitcnt_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    regs_d      = regs_q;
    commit_c    = 1'b0;
    rd_data_d   = '0;

    case (state_q)
      ST_SETTLE: begin
        settle_d = settle_q + STW'(1);
        if (settle_q == STW'(SYNC)) state_d = le_s ? ST_IDLE : ST_WAIT;
      end
      ST_IDLE: begin
        if (le_fall_c) begin
          state_d  = ST_SHIFT;
          sr_d     = '0;
          bitcnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (le_rise_c) begin
          state_d = ST_IDLE;
          if (bitcnt_q == CW'(32)) commit_c = 1'b1;
          else                     frame_err_d = 1'b1;
        end else if (clk_rise_c) begin
          sr_d = {sr_q[FW-2:0], din_s};
          if (bitcnt_q != CW'(33)) bitcnt_d = bitcnt_q + CW'(1);
        end
      end
      ST_WAIT: begin
        if (le_rise_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit_c && ({1'b0, fr_addr_c} < NREG_L)) begin
      regs_d[fr_addr_c[IW-1:0]] = fr_data_c;
      wr_stb_d  = 1'b1;
      wr_addr_d = fr_addr_c;
      wr_data_d = fr_data_c;
    end

    if ({1'b0, rd_addr} < NREG_L) rd_data_d = regs_q[rd_addr[IW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SETTLE;
      le_sync_q   <= '1;
      clk_sync_q  <= '0;
      din_sync_q  <= '0;
      le_h_q      <= 1'b1;
      clk_h_q     <= 1'b0;
      settle_q    <= '0;
      sr_q        <= '0;
      bitcnt_q    <= '0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      rd_data_q   <= '0;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      le_sync_q   <= le_sync_d;
      clk_sync_q  <= clk_sync_d;
      din_sync_q  <= din_sync_d;
      le_h_q      <= le_s;
      clk_h_q     <= clk_s;
      settle_q    <= settle_d;
      sr_q        <= sr_d;
      bitcnt_q    <= bitcnt_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      rd_data_q   <= rd_data_d;
      regs_q      <= regs_d;
    end
  end

  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign rd_data   = rd_data_q;

`ifdef UWIRE_READBACK_EN
  logic          clk_fall_c;
  logic [3:0]    rb_ptr_q, rb_ptr_d;
  logic          rb_vld_q, rb_vld_d, doe_q, doe_d, dout_q, dout_d;
  logic [FW-1:0] rb_sr_q, rb_sr_d, rb_word_c;

  assign clk_fall_c = ~clk_s & clk_h_q;

  // Readback pointer and serializer; word is loaded at LE fall, shifted on uw_clk falls
  always_comb begin
    rb_ptr_d  = rb_ptr_q;
    rb_vld_d  = rb_vld_q;
    rb_sr_d   = rb_sr_q;
    doe_d     = doe_q;
    dout_d    = dout_q;
    rb_word_c = {DW'(0), rb_ptr_q};
    if ({1'b0, rb_ptr_q} < NREG_L) rb_word_c = {regs_q[rb_ptr_q[IW-1:0]], rb_ptr_q};

    if (state_q == ST_IDLE && le_fall_c && rb_vld_q) begin
      doe_d   = 1'b1;
      dout_d  = rb_word_c[FW-1];
      rb_sr_d = {rb_word_c[FW-2:0], 1'b0};
    end else if (doe_q && state_q == ST_SHIFT && clk_fall_c && !le_rise_c) begin
      dout_d  = rb_sr_q[FW-1];
      rb_sr_d = {rb_sr_q[FW-2:0], 1'b0};
    end

    if (state_q == ST_SHIFT && le_rise_c) begin
      doe_d    = 1'b0;
      dout_d   = 1'b0;
      rb_vld_d = 1'b0;
    end

    if (commit_c && fr_addr_c == 4'(RB_ADDR)) begin
      rb_ptr_d = fr_data_c[3:0];
      rb_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_ptr_q <= '0;
      rb_vld_q <= 1'b0;
      rb_sr_q  <= '0;
      doe_q    <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      rb_ptr_q <= rb_ptr_d;
      rb_vld_q <= rb_vld_d;
      rb_sr_q  <= rb_sr_d;
      doe_q    <= doe_d;
      dout_q   <= dout_d;
    end
  end

  assign uw_dout = dout_q;
  assign uw_doe  = doe_q;
`else
  assign uw_dout = 1'b0;
  assign uw_doe  = 1'b0;
`endif

endmodule

// File: tb/tb_uwire_responder.sv
// Directed bench for uwire_responder (NREG=8): writes, framing errors, range drop,
// reset mid-frame and readback (serializer checked only when UWIRE_READBACK_EN is set).
module tb_uwire_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uw_clk = 1'b0;
  logic        uw_le = 1'b1;
  logic        uw_din = 1'b0;
  logic        uw_dout, uw_doe, wr_stb, frame_err;
  logic [3:0]  wr_addr;
  logic [27:0] wr_data, rd_data;
  logic [3:0]  rd_addr = 4'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int stb_n = 0;
  int err_n = 0;
  logic [3:0]  last_addr = '0;
  logic [27:0] last_data = '0;

  uwire_responder #(.NREG(8), .RB_ADDR(15), .SYNC(2)) dut (
    .clk(clk), .rst(rst), .uw_clk(uw_clk), .uw_le(uw_le), .uw_din(uw_din),
    .uw_dout(uw_dout), .uw_doe(uw_doe), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_err(frame_err), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_stb) begin
      stb_n     <= stb_n + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (frame_err) err_n <= err_n + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Shifts n bits of v MSB first; captures uw_dout before each rising uw_clk edge
  task automatic send_frame(input logic [63:0] v, input int n,
                            output logic [31:0] cap, output logic doe0);
    cap  = '0;
    doe0 = 1'b0;
    uw_le = 1'b0;
    #80;
    for (int i = n - 1; i >= 0; i--) begin
      uw_din = v[i];
      #80;
      if (i == n - 1) doe0 = uw_doe;
      cap = {cap[30:0], uw_dout};
      uw_clk = 1'b1;
      #80;
      uw_clk = 1'b0;
    end
    #80 uw_le = 1'b1;
    #200;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [27:0] d);
    rd_addr = a;
    repeat (2) @(posedge clk);
    #1 d = rd_data;
  endtask

  initial begin
    logic [31:0] cap;
    logic        doe0;
    logic [27:0] d;
    int s0, e0;

    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_wr_stb",    32'(wr_stb), 32'h0);
    check_eq("rst_frame_err", 32'(frame_err), 32'h0);
    check_eq("rst_wr_addr",   32'(wr_addr), 32'h0);
    check_eq("rst_wr_data",   32'(wr_data), 32'h0);
    check_eq("rst_rd_data",   32'(rd_data), 32'h0);
    check_eq("rst_doe",       32'(uw_doe), 32'h0);
    check_eq("rst_dout",      32'(uw_dout), 32'h0);
    rst = 1'b0;
    #200;

    // good write
    s0 = stb_n; e0 = err_n;
    send_frame(64'hABCDEF13, 32, cap, doe0);
    check_eq("t1_stb_cnt", 32'(stb_n - s0), 32'd1);
    check_eq("t1_err_cnt", 32'(err_n - e0), 32'd0);
    check_eq("t1_wr_addr", 32'(last_addr), 32'h3);
    check_eq("t1_wr_data", 32'(last_data), 32'hABCDEF1);
    read_reg(4'd3, d);
    check_eq("t1_rd3", 32'(d), 32'hABCDEF1);

    // 31-bit, 33-bit and empty frames
    s0 = stb_n; e0 = err_n;
    send_frame(64'h12345672, 31, cap, doe0);
    check_eq("t2_err_cnt", 32'(err_n - e0), 32'd1);
    check_eq("t2_stb_cnt", 32'(stb_n - s0), 32'd0);
    s0 = stb_n; e0 = err_n;
    send_frame(64'h1_5555_5553, 33, cap, doe0);
    check_eq("t3_err_cnt", 32'(err_n - e0), 32'd1);
    check_eq("t3_stb_cnt", 32'(stb_n - s0), 32'd0);
    s0 = stb_n; e0 = err_n;
    send_frame(64'h0, 0, cap, doe0);
    check_eq("t3b_err_cnt", 32'(err_n - e0), 32'd1);
    check_eq("t3b_stb_cnt", 32'(stb_n - s0), 32'd0);
    read_reg(4'd3, d);
    check_eq("t3_rd3_kept", 32'(d), 32'hABCDEF1);

    // address beyond NREG is dropped silently
    s0 = stb_n; e0 = err_n;
    send_frame(64'h55555559, 32, cap, doe0);
    check_eq("t4_stb_cnt", 32'(stb_n - s0), 32'd0);
    check_eq("t4_err_cnt", 32'(err_n - e0), 32'd0);
    read_reg(4'd9, d);
    check_eq("t4_rd9", 32'(d), 32'h0);

    // reset after 16 bits with LE held low
    s0 = stb_n; e0 = err_n;
    uw_le = 1'b0;
    #80;
    for (int i = 0; i < 16; i++) begin
      uw_din = i[0];
      #80 uw_clk = 1'b1;
      #80 uw_clk = 1'b0;
    end
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #400 uw_le = 1'b1;
    #300;
    check_eq("t5_err_cnt", 32'(err_n - e0), 32'd0);
    check_eq("t5_stb_cnt", 32'(stb_n - s0), 32'd0);
    read_reg(4'd3, d);
    check_eq("t5_rd3_cleared", 32'(d), 32'h0);
    send_frame(64'h0C0FFEE1, 32, cap, doe0);
    check_eq("t5_stb_after", 32'(stb_n - s0), 32'd1);
    check_eq("t5_wr_addr", 32'(last_addr), 32'h1);
    read_reg(4'd1, d);
    check_eq("t5_rd1", 32'(d), 32'h0C0FFEE);

    // readback of reg 5
    send_frame(64'h12345675, 32, cap, doe0);
    read_reg(4'd5, d);
    check_eq("t6_rd5", 32'(d), 32'h1234567);
    send_frame(64'h0000005F, 32, cap, doe0);
    send_frame(64'h00000000, 32, cap, doe0);
`ifdef UWIRE_READBACK_EN
    check_eq("t6_doe_active", 32'(doe0), 32'h1);
    check_eq("t6_rb_word", cap, 32'h12345675);
`else
    check_eq("t6_doe_active", 32'(doe0), 32'h0);
    check_eq("t6_rb_word", cap, 32'h0);
`endif
    check_eq("t6_doe_after", 32'(uw_doe), 32'h0);
    check_eq("t6_dout_after", 32'(uw_dout), 32'h0);
    send_frame(64'h00000000, 32, cap, doe0);
    check_eq("t6_no_second_rb", 32'(doe0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
